rdata_axis_packer: RTL and testbench

- Downstream stage of the DDR read path: takes raw 512-bit read beats from the command scheduler / DDR interface and frames them into the M_AXIS_RDATA stream consumed by the PS interface DMA (S2MM).
- Buffers beats because the DDR side cannot be back-pressured.
- Delimits packets with tlast using a per-transfer beat count supplied by the command path.
- Flags overflow when the buffer cannot absorb a beat.

---
 rtl/sddt_rdata_pkg.sv | 15 +
 rtl/rdata_fifo.sv | 63 ++++++
 rtl/rdata_axis_packer.sv | 140 ++++++++++++++
 tb/tb_rdata_axis_packer.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sddt_rdata_pkg.sv
// rtl/sddt_rdata_pkg.sv - shared widths, keep constant and state enum for the read-data packer
package sddt_rdata_pkg;

    localparam int DATA_W = 512;
    localparam int KEEP_W = DATA_W / 8;
    localparam int LEN_W  = 16;

    localparam logic [KEEP_W-1:0] KEEP_ALL = '1;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

endpackage

// File: rtl/rdata_fifo.sv
// rtl/rdata_fifo.sv - synchronous first-word-fall-through beat FIFO with count/full/empty
module rdata_fifo #(
    parameter int W     = 512,
    parameter int DEPTH = 64,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [W-1:0]     wr_data,
    input  logic             rd_en,
    output logic [W-1:0]     rd_data,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          wr_ok;
    logic          rd_ok;

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);
    // A read frees the slot on the same edge, so a full FIFO still takes a write alongside a read.
    assign rd_ok = rd_en & ~empty;
    assign wr_ok = wr_en & (~full | rd_ok);

    // Head of queue is visible combinationally so a freshly written beat is presentable next cycle.
    assign rd_data = mem[rd_ptr];

    // Storage array; not reset, contents are qualified by count.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/rdata_axis_packer.sv
// rtl/rdata_axis_packer.sv - frames DDR read beats into an AXIS packet stream; optional RDATA_PACKER_STATS_EN counters
module rdata_axis_packer
    import sddt_rdata_pkg::*;
#(
    parameter int DATA_W     = 512,
    parameter int KEEP_W     = 64,
    parameter int LEN_W      = 16,
    parameter int FIFO_DEPTH = 64,
    parameter int CNT_W      = 7
) (
    input  logic              c0_ddr4_clk,
    input  logic              c0_ddr4_rst,
    input  logic              rd_data_valid,
    input  logic [DATA_W-1:0] rd_data,
    input  logic              xfer_len_valid,
    output logic              xfer_len_ready,
    input  logic [LEN_W-1:0]  xfer_len,
    output logic [DATA_W-1:0] M_AXIS_RDATA_tdata,
    output logic [KEEP_W-1:0] M_AXIS_RDATA_tkeep,
    output logic              M_AXIS_RDATA_tlast,
    output logic              M_AXIS_RDATA_tvalid,
    input  logic              M_AXIS_RDATA_tready,
    output logic              err,
    input  logic              err_clr,
    output logic [CNT_W-1:0]  fifo_count,
`ifdef RDATA_PACKER_STATS_EN
    output logic [31:0]       stat_beats,
    output logic [31:0]       stat_pkts,
    output logic [15:0]       stat_drops,
`endif
    output logic              busy
);

    state_t             state;
    logic [LEN_W-1:0]   remaining;
    logic [DATA_W-1:0]  head;
    logic               fifo_full;
    logic               fifo_empty;
    logic               out_hs;
    logic               is_last;
    logic               overflow;

    // The DDR side has no ready, so every beat is offered to the FIFO; a full FIFO drops it.
    rdata_fifo #(
        .W     (DATA_W),
        .DEPTH (FIFO_DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk     (c0_ddr4_clk),
        .rst     (c0_ddr4_rst),
        .wr_en   (rd_data_valid),
        .wr_data (rd_data),
        .rd_en   (out_hs),
        .rd_data (head),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign is_last  = (remaining == LEN_W'(1));
    assign out_hs   = M_AXIS_RDATA_tvalid & M_AXIS_RDATA_tready;
    assign overflow = rd_data_valid & fifo_full & ~out_hs;

    // Stream outputs derive from state and FIFO registers only, so they hold until the handshake.
    assign M_AXIS_RDATA_tvalid = (state == STREAM) & ~fifo_empty;
    assign M_AXIS_RDATA_tdata  = M_AXIS_RDATA_tvalid ? head : '0;
    assign M_AXIS_RDATA_tlast  = M_AXIS_RDATA_tvalid & is_last;
    assign M_AXIS_RDATA_tkeep  = (state == STREAM) ? KEEP_W'(KEEP_ALL) : '0;

    assign busy = (state != IDLE) | (fifo_count != '0);

    // Packet FSM: accept a descriptor in IDLE, count handshakes down in STREAM.
    always_ff @(posedge c0_ddr4_clk) begin
        if (c0_ddr4_rst) begin
            state          <= IDLE;
            remaining      <= '0;
            xfer_len_ready <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    xfer_len_ready <= 1'b1;
                    if (xfer_len_valid && xfer_len_ready && (xfer_len != '0)) begin
                        remaining      <= xfer_len;
                        state          <= STREAM;
                        xfer_len_ready <= 1'b0;
                    end
                end
                STREAM: begin
                    xfer_len_ready <= 1'b0;
                    if (out_hs) begin
                        remaining <= remaining - LEN_W'(1);
                        if (is_last) begin
                            state          <= IDLE;
                            xfer_len_ready <= 1'b1;
                        end
                    end
                end
                default: begin
                    state          <= IDLE;
                    xfer_len_ready <= 1'b0;
                end
            endcase
        end
    end

    // Sticky overflow flag; a new drop outranks a clear on the same edge.
    always_ff @(posedge c0_ddr4_clk) begin
        if (c0_ddr4_rst) begin
            err <= 1'b0;
        end else if (overflow) begin
            err <= 1'b1;
        end else if (err_clr) begin
            err <= 1'b0;
        end
    end

`ifdef RDATA_PACKER_STATS_EN
    // Traffic counters: beats and packets wrap, drops saturate and are cleared with err.
    always_ff @(posedge c0_ddr4_clk) begin
        if (c0_ddr4_rst) begin
            stat_beats <= '0;
            stat_pkts  <= '0;
            stat_drops <= '0;
        end else begin
            if (out_hs) begin
                stat_beats <= stat_beats + 32'd1;
            end
            if (out_hs && M_AXIS_RDATA_tlast) begin
                stat_pkts <= stat_pkts + 32'd1;
            end
            if (err_clr) begin
                stat_drops <= overflow ? 16'd1 : 16'd0;
            end else if (overflow && (stat_drops != 16'hFFFF)) begin
                stat_drops <= stat_drops + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_rdata_axis_packer.sv
// tb/tb_rdata_axis_packer.sv - directed self-checking bench for rdata_axis_packer
module tb_rdata_axis_packer;

    localparam int DATA_W     = 512;
    localparam int KEEP_W     = 64;
    localparam int LEN_W      = 16;
    localparam int FIFO_DEPTH = 64;
    localparam int CNT_W      = 7;

    logic              clk = 1'b0;
    logic              rst;
    logic              rd_data_valid;
    logic [DATA_W-1:0] rd_data;
    logic              xfer_len_valid;
    logic              xfer_len_ready;
    logic [LEN_W-1:0]  xfer_len;
    logic [DATA_W-1:0] tdata;
    logic [KEEP_W-1:0] tkeep;
    logic              tlast;
    logic              tvalid;
    logic              tready;
    logic              err;
    logic              err_clr;
    logic [CNT_W-1:0]  fifo_count;
    logic              busy;
`ifdef RDATA_PACKER_STATS_EN
    logic [31:0]       stat_beats;
    logic [31:0]       stat_pkts;
    logic [15:0]       stat_drops;
`endif

    int tests = 0;
    int fails = 0;

    logic [DATA_W-1:0] obs_data [$];
    bit                obs_last [$];

    logic              prev_v;
    logic              prev_r;
    logic              prev_rst;
    logic              prev_l;
    logic [DATA_W-1:0] prev_d;

    localparam logic [KEEP_W-1:0] KEEP_ONES = '1;

    always #5 clk = ~clk;

    rdata_axis_packer #(
        .DATA_W     (DATA_W),
        .KEEP_W     (KEEP_W),
        .LEN_W      (LEN_W),
        .FIFO_DEPTH (FIFO_DEPTH),
        .CNT_W      (CNT_W)
    ) dut (
        .c0_ddr4_clk         (clk),
        .c0_ddr4_rst         (rst),
        .rd_data_valid       (rd_data_valid),
        .rd_data             (rd_data),
        .xfer_len_valid      (xfer_len_valid),
        .xfer_len_ready      (xfer_len_ready),
        .xfer_len            (xfer_len),
        .M_AXIS_RDATA_tdata  (tdata),
        .M_AXIS_RDATA_tkeep  (tkeep),
        .M_AXIS_RDATA_tlast  (tlast),
        .M_AXIS_RDATA_tvalid (tvalid),
        .M_AXIS_RDATA_tready (tready),
        .err                 (err),
        .err_clr             (err_clr),
        .fifo_count          (fifo_count),
`ifdef RDATA_PACKER_STATS_EN
        .stat_beats          (stat_beats),
        .stat_pkts           (stat_pkts),
        .stat_drops          (stat_drops),
`endif
        .busy                (busy)
    );

    task automatic check(input string tag, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // One cycle: sample outputs at the falling edge, then cross the rising edge.
    task automatic tick();
        @(negedge clk);
        if (prev_v && !prev_r && !prev_rst) begin
            check("hold_valid", tvalid, 1);
            check("hold_data", tdata, prev_d);
            check("hold_last", tlast, prev_l);
        end
        if (tvalid && tready && !rst) begin
            obs_data.push_back(tdata);
            obs_last.push_back(tlast);
            check("hs_tkeep", tkeep, KEEP_ONES);
        end
        prev_v   = tvalid;
        prev_r   = tready;
        prev_rst = rst;
        prev_l   = tlast;
        prev_d   = tdata;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic put_beat(input logic [DATA_W-1:0] d);
        rd_data_valid = 1'b1;
        rd_data       = d;
        tick();
        rd_data_valid = 1'b0;
    endtask

    task automatic send_desc(input int len);
        int n;
        n = 0;
        xfer_len       = LEN_W'(len);
        xfer_len_valid = 1'b1;
        while (!xfer_len_ready && n < 100) begin
            tick();
            n++;
        end
        check("desc_ready", xfer_len_ready, 1);
        tick();
        xfer_len_valid = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_tvalid"}, tvalid, 0);
        check({tag, "_tlast"}, tlast, 0);
        check({tag, "_tkeep"}, tkeep, 0);
        check({tag, "_tdata"}, tdata, 0);
        check({tag, "_ready"}, xfer_len_ready, 0);
        check({tag, "_err"}, err, 0);
        check({tag, "_count"}, fifo_count, 0);
        check({tag, "_busy"}, busy, 0);
    endtask

    task automatic clear_obs();
        obs_data.delete();
        obs_last.delete();
    endtask

    initial begin
        int nlast;
        int bad;
        rst = 1'b1;
        rd_data_valid = 1'b0;
        rd_data = '0;
        xfer_len_valid = 1'b0;
        xfer_len = '0;
        tready = 1'b0;
        err_clr = 1'b0;
        prev_v = 1'b0;
        prev_r = 1'b0;
        prev_rst = 1'b1;
        prev_l = 1'b0;
        prev_d = '0;

        // Reset state
        @(posedge clk);
        #1;
        idle(2);
        check_reset_vals("rst0");
        rst = 1'b0;
        tick();
        check("rst0_ready_after", xfer_len_ready, 1);

        // Basic 4-beat packet
        tready = 1'b1;
        send_desc(4);
        check("t1_busy_stream", busy, 1);
        for (int i = 1; i <= 4; i++) put_beat(DATA_W'(i));
        idle(4);
        check("t1_count", obs_data.size(), 4);
        if (obs_data.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                check("t1_data", obs_data[i], DATA_W'(i + 1));
                check("t1_last", obs_last[i], (i == 3) ? 1 : 0);
            end
        end
        check("t1_busy_end", busy, 0);
        check("t1_ready_end", xfer_len_ready, 1);
        clear_obs();

        // Beats ahead of the descriptor wait in the FIFO
        put_beat(DATA_W'(32'hA));
        put_beat(DATA_W'(32'hB));
        idle(10);
        check("t2_tvalid_idle", tvalid, 0);
        check("t2_fifo_count", fifo_count, 2);
        check("t2_no_output", obs_data.size(), 0);
        check("t2_busy", busy, 1);
        send_desc(2);
        idle(4);
        check("t2_count", obs_data.size(), 2);
        if (obs_data.size() == 2) begin
            check("t2_data0", obs_data[0], DATA_W'(32'hA));
            check("t2_last0", obs_last[0], 0);
            check("t2_data1", obs_data[1], DATA_W'(32'hB));
            check("t2_last1", obs_last[1], 1);
        end
        clear_obs();

        // Toggling tready with an 8-beat packet
        send_desc(8);
        for (int i = 0; i < 8; i++) begin
            tready = (i % 2 == 0);
            put_beat(DATA_W'(32'h10 + i));
        end
        for (int i = 0; i < 24; i++) begin
            tready = (i % 2 == 0);
            tick();
        end
        tready = 1'b1;
        check("t3_count", obs_data.size(), 8);
        nlast = 0;
        bad = 0;
        foreach (obs_data[i]) begin
            if (obs_last[i]) nlast++;
            if (obs_data[i] !== DATA_W'(32'h10 + i)) bad++;
        end
        check("t3_nlast", nlast, 1);
        check("t3_order_errs", bad, 0);
        if (obs_last.size() == 8) check("t3_last_pos", obs_last[7], 1);
        idle(2);
        clear_obs();

        // Overflow while stalled
        tready = 1'b0;
        send_desc(FIFO_DEPTH);
        for (int i = 0; i < FIFO_DEPTH + 3; i++) put_beat(DATA_W'(32'h100 + i));
        check("t4_full_count", fifo_count, FIFO_DEPTH);
        check("t4_err_set", err, 1);
        check("t4_busy", busy, 1);
        rd_data_valid = 1'b1;
        rd_data = DATA_W'(32'hDEAD);
        err_clr = 1'b1;
        tick();
        rd_data_valid = 1'b0;
        check("t4_set_wins", err, 1);
        tick();
        err_clr = 1'b0;
        check("t4_err_cleared", err, 0);
        tready = 1'b1;
        idle(FIFO_DEPTH + 6);
        check("t4_count", obs_data.size(), FIFO_DEPTH);
        nlast = 0;
        bad = 0;
        foreach (obs_data[i]) begin
            if (obs_last[i]) nlast++;
            if (obs_data[i] !== DATA_W'(32'h100 + i)) bad++;
        end
        check("t4_order_errs", bad, 0);
        check("t4_nlast", nlast, 1);
        check("t4_fifo_empty", fifo_count, 0);
        clear_obs();

        // Zero-length descriptor then a single beat
        send_desc(0);
        check("t5_ready_zero", xfer_len_ready, 1);
        check("t5_busy_zero", busy, 0);
        idle(2);
        check("t5_no_output", obs_data.size(), 0);
        send_desc(1);
        put_beat(DATA_W'(32'h55));
        idle(4);
        check("t5_count", obs_data.size(), 1);
        if (obs_data.size() == 1) begin
            check("t5_data", obs_data[0], DATA_W'(32'h55));
            check("t5_last", obs_last[0], 1);
        end
        clear_obs();

        // Reset in the middle of a packet
        send_desc(5);
        put_beat(DATA_W'(32'h1));
        put_beat(DATA_W'(32'h2));
        put_beat(DATA_W'(32'h3));
        tready = 1'b0;
        rst = 1'b1;
        tick();
        check_reset_vals("t6_rst");
        check("t6_emitted", obs_data.size(), 2);
        if (obs_last.size() == 2) begin
            check("t6_nolast0", obs_last[0], 0);
            check("t6_nolast1", obs_last[1], 0);
        end
        rst = 1'b0;
        tready = 1'b1;
        idle(2);
        send_desc(1);
        put_beat(DATA_W'(32'h77));
        idle(4);
        check("t6_count_after", obs_data.size(), 3);
        if (obs_data.size() == 3) begin
            check("t6_data", obs_data[2], DATA_W'(32'h77));
            check("t6_last", obs_last[2], 1);
        end
        check("t6_busy_end", busy, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
